// File: rtl/glyph_pkg.sv
// Shared types and constants for the glyph feature extractor.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package glyph_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SCAN,
        ST_DRAIN,
        ST_DONE
    } state_t;

    localparam logic [7:0] CHAR_BLANK_DEF = 8'h20;
    localparam logic [7:0] CHAR_WIDE_DEF  = 8'h2D;
    localparam logic [7:0] CHAR_TALL_DEF  = 8'h49;
    localparam logic [7:0] CHAR_INK_DEF   = 8'h41;

    // Bits needed to index n items; never narrower than one bit.
    function automatic int coord_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Bits needed to hold a count from 0 to n inclusive.
    function automatic int count_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/glyph_feature_extractor_rd_tag_pipe.sv
// Delay line carrying {valid, x, y} alongside each RAM read so returns arrive tagged.
// Latency: RD_LAT cycles from input to output.
// Backpressure: none; flush kills every in-flight tag synchronously.
module rd_tag_pipe #(
    parameter int RD_LAT = 1,
    parameter int XW     = 5,
    parameter int YW     = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic          in_valid,
    input  logic [XW-1:0] in_x,
    input  logic [YW-1:0] in_y,
    output logic          out_valid,
    output logic [XW-1:0] out_x,
    output logic [YW-1:0] out_y
);

    logic [RD_LAT-1:0] vld_q;
    logic [XW-1:0]     x_q [RD_LAT];
    logic [YW-1:0]     y_q [RD_LAT];

    // Shift tags one stage per cycle; only the valids need clearing to drop stale reads.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            vld_q <= '0;
        end else begin
            vld_q[0] <= in_valid;
            for (int i = 1; i < RD_LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
            end
        end
        x_q[0] <= in_x;
        y_q[0] <= in_y;
        for (int i = 1; i < RD_LAT; i++) begin
            x_q[i] <= x_q[i-1];
            y_q[i] <= y_q[i-1];
        end
    end

    assign out_valid = vld_q[RD_LAT-1];
    assign out_x     = x_q[RD_LAT-1];
    assign out_y     = y_q[RD_LAT-1];

endmodule

// File: rtl/glyph_feature_extractor.sv
// Scans a WxH 1-bit canvas RAM after end_write, accumulates ink count and bbox, classifies the glyph.
// Latency: result_valid rises N+RD_LAT+1 cycles after the end_write cycle.
// Backpressure: result held stable in DONE until result_ready; end_write anywhere restarts the scan.
module glyph_feature_extractor
    import glyph_pkg::*;
#(
    parameter int         CANVAS_W   = 32,
    parameter int         CANVAS_H   = 32,
    parameter int         RD_LAT     = 1,
    parameter logic [7:0] CHAR_BLANK = CHAR_BLANK_DEF,
    parameter logic [7:0] CHAR_WIDE  = CHAR_WIDE_DEF,
    parameter logic [7:0] CHAR_TALL  = CHAR_TALL_DEF,
    parameter logic [7:0] CHAR_INK   = CHAR_INK_DEF,
    localparam int N  = CANVAS_W * CANVAS_H,
    localparam int AW = coord_w(N),
    localparam int XW = coord_w(CANVAS_W),
    localparam int YW = coord_w(CANVAS_H),
    localparam int CW = count_w(N)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          end_write,
    output logic          read_enable,
    output logic [AW-1:0] read_addr,
    input  logic          read_in_data,
    output logic          busy,
    output logic          result_valid,
    input  logic          result_ready,
    output logic [7:0]    result_char,
    output logic [CW-1:0] ink_count,
    output logic [XW-1:0] bbox_x0,
    output logic [XW-1:0] bbox_x1,
    output logic [YW-1:0] bbox_y0,
    output logic [YW-1:0] bbox_y1
);

    localparam logic [AW-1:0] ADDR_LAST = AW'(N - 1);
    localparam logic [XW-1:0] X_LAST    = XW'(CANVAS_W - 1);
    localparam logic [YW-1:0] Y_LAST    = YW'(CANVAS_H - 1);
    // Wide enough for a bbox extent (up to 2^max(XW,YW)) doubled.
    localparam int DW = ((XW > YW) ? XW : YW) + 2;

    state_t        state, state_nxt;
    logic          enter_done;
    logic          last_return;
    logic [XW-1:0] scan_x;
    logic [YW-1:0] scan_y;
    logic          tag_vld;
    logic [XW-1:0] tag_x;
    logic [YW-1:0] tag_y;

    logic [CW-1:0] acc_ink, acc_ink_nxt;
    logic [XW-1:0] acc_x0, acc_x0_nxt, acc_x1, acc_x1_nxt;
    logic [YW-1:0] acc_y0, acc_y0_nxt, acc_y1, acc_y1_nxt;
    logic [DW-1:0] box_w, box_h;
    logic [7:0]    class_char;

    rd_tag_pipe #(
        .RD_LAT (RD_LAT),
        .XW     (XW),
        .YW     (YW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .flush     (end_write),
        .in_valid  (read_enable),
        .in_x      (scan_x),
        .in_y      (scan_y),
        .out_valid (tag_vld),
        .out_x     (tag_x),
        .out_y     (tag_y)
    );

    // The bottom-right pixel is the last one issued, so its tag marks the end of the drain.
    assign last_return  = tag_vld && (tag_x == X_LAST) && (tag_y == Y_LAST);
    assign busy         = (state == ST_SCAN) || (state == ST_DRAIN);
    assign result_valid = (state == ST_DONE);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; end_write restarts from any state and outranks the handshake.
    always_comb begin
        state_nxt  = state;
        enter_done = 1'b0;
        case (state)
            ST_IDLE: begin
                if (end_write) state_nxt = ST_SCAN;
            end
            ST_SCAN: begin
                if (end_write)                    state_nxt = ST_SCAN;
                else if (read_addr == ADDR_LAST)  state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (end_write) begin
                    state_nxt = ST_SCAN;
                end else if (last_return) begin
                    state_nxt  = ST_DONE;
                    enter_done = 1'b1;
                end
            end
            ST_DONE: begin
                if (end_write)         state_nxt = ST_SCAN;
                else if (result_ready) state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address generator: linear address plus x/y counters so tags need no division.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_enable <= 1'b0;
            read_addr   <= '0;
            scan_x      <= '0;
            scan_y      <= '0;
        end else if (end_write) begin
            read_enable <= 1'b1;
            read_addr   <= '0;
            scan_x      <= '0;
            scan_y      <= '0;
        end else if (state == ST_SCAN) begin
            if (read_addr == ADDR_LAST) begin
                read_enable <= 1'b0;
            end else begin
                read_addr <= read_addr + AW'(1);
                if (scan_x == X_LAST) begin
                    scan_x <= '0;
                    scan_y <= scan_y + YW'(1);
                end else begin
                    scan_x <= scan_x + XW'(1);
                end
            end
        end
    end

    // Fold a returning ink pixel into count and bbox; the first ink pixel seeds the box.
    always_comb begin
        acc_ink_nxt = acc_ink;
        acc_x0_nxt  = acc_x0;
        acc_x1_nxt  = acc_x1;
        acc_y0_nxt  = acc_y0;
        acc_y1_nxt  = acc_y1;
        if (tag_vld && read_in_data) begin
            acc_ink_nxt = acc_ink + CW'(1);
            if (acc_ink == '0) begin
                acc_x0_nxt = tag_x;
                acc_x1_nxt = tag_x;
                acc_y0_nxt = tag_y;
                acc_y1_nxt = tag_y;
            end else begin
                if (tag_x < acc_x0) acc_x0_nxt = tag_x;
                if (tag_x > acc_x1) acc_x1_nxt = tag_x;
                if (tag_y < acc_y0) acc_y0_nxt = tag_y;
                if (tag_y > acc_y1) acc_y1_nxt = tag_y;
            end
        end
    end

    // Accumulators restart on every end_write so an aborted scan leaves no trace.
    always_ff @(posedge clk) begin
        if (rst || end_write) begin
            acc_ink <= '0;
            acc_x0  <= '0;
            acc_x1  <= '0;
            acc_y0  <= '0;
            acc_y1  <= '0;
        end else begin
            acc_ink <= acc_ink_nxt;
            acc_x0  <= acc_x0_nxt;
            acc_x1  <= acc_x1_nxt;
            acc_y0  <= acc_y0_nxt;
            acc_y1  <= acc_y1_nxt;
        end
    end

    // Classify from the post-update values so the final pixel is included.
    always_comb begin
        box_w = DW'(acc_x1_nxt) - DW'(acc_x0_nxt) + DW'(1);
        box_h = DW'(acc_y1_nxt) - DW'(acc_y0_nxt) + DW'(1);
        if (acc_ink_nxt == '0)       class_char = CHAR_BLANK;
        else if (box_w >= (box_h << 1)) class_char = CHAR_WIDE;
        else if (box_h >= (box_w << 1)) class_char = CHAR_TALL;
        else                         class_char = CHAR_INK;
    end

    // Result registers load on entry to DONE and otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_char <= CHAR_BLANK;
            ink_count   <= '0;
            bbox_x0     <= '0;
            bbox_x1     <= '0;
            bbox_y0     <= '0;
            bbox_y1     <= '0;
        end else if (enter_done) begin
            result_char <= class_char;
            ink_count   <= acc_ink_nxt;
            bbox_x0     <= acc_x0_nxt;
            bbox_x1     <= acc_x1_nxt;
            bbox_y0     <= acc_y0_nxt;
            bbox_y1     <= acc_y1_nxt;
        end
    end

endmodule

// File: tb/tb_glyph_feature_extractor.sv
// Randomised bench for glyph_feature_extractor against a whole-canvas reference model.
// Two instances: defaults (32x32, RD_LAT=1) and 16x8 with RD_LAT=3.
// One shared stimulus path selected by sel.
module tb_glyph_feature_extractor;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic ew;
    logic rdy;
    int   sel;
    int   cur_w, cur_h, cur_lat;

    int n_vec = 0;
    int n_err = 0;

    bit canvas [1024];

    // Default instance signals
    logic       d_ew, d_re, d_rdata, d_busy, d_rv, d_rdy;
    logic [9:0] d_addr;
    logic [7:0] d_char;
    logic [10:0] d_ink;
    logic [4:0] d_x0, d_x1, d_y0, d_y1;

    // Small instance signals
    logic       s_ew, s_re, s_rdata, s_busy, s_rv, s_rdy;
    logic [6:0] s_addr;
    logic [7:0] s_char;
    logic [7:0] s_ink;
    logic [3:0] s_x0, s_x1;
    logic [2:0] s_y0, s_y1;

    assign d_ew  = ew  && (sel == 0);
    assign s_ew  = ew  && (sel == 1);
    assign d_rdy = rdy && (sel == 0);
    assign s_rdy = rdy && (sel == 1);

    glyph_feature_extractor dut (
        .clk(clk), .rst(rst), .end_write(d_ew),
        .read_enable(d_re), .read_addr(d_addr), .read_in_data(d_rdata),
        .busy(d_busy), .result_valid(d_rv), .result_ready(d_rdy),
        .result_char(d_char), .ink_count(d_ink),
        .bbox_x0(d_x0), .bbox_x1(d_x1), .bbox_y0(d_y0), .bbox_y1(d_y1)
    );

    glyph_feature_extractor #(.CANVAS_W(16), .CANVAS_H(8), .RD_LAT(3)) dut_s (
        .clk(clk), .rst(rst), .end_write(s_ew),
        .read_enable(s_re), .read_addr(s_addr), .read_in_data(s_rdata),
        .busy(s_busy), .result_valid(s_rv), .result_ready(s_rdy),
        .result_char(s_char), .ink_count(s_ink),
        .bbox_x0(s_x0), .bbox_x1(s_x1), .bbox_y0(s_y0), .bbox_y1(s_y1)
    );

    // Canvas RAM models: data appears RD_LAT cycles after the strobe; junk when not strobed.
    logic [2:0] d_pipe, s_pipe;
    always @(posedge clk) begin
        d_pipe <= {d_pipe[1:0], d_re ? canvas[d_addr] : (($urandom % 2) == 1)};
        s_pipe <= {s_pipe[1:0], s_re ? canvas[s_addr] : (($urandom % 2) == 1)};
    end
    assign d_rdata = d_pipe[0];
    assign s_rdata = s_pipe[2];

    // Selected-instance view
    int unsigned o_re, o_addr, o_busy, o_rv, o_char, o_ink, o_x0, o_x1, o_y0, o_y1;
    always_comb begin
        if (sel == 0) begin
            o_re = d_re; o_addr = d_addr; o_busy = d_busy; o_rv = d_rv; o_char = d_char;
            o_ink = d_ink; o_x0 = d_x0; o_x1 = d_x1; o_y0 = d_y0; o_y1 = d_y1;
        end else begin
            o_re = s_re; o_addr = s_addr; o_busy = s_busy; o_rv = s_rv; o_char = s_char;
            o_ink = s_ink; o_x0 = s_x0; o_x1 = s_x1; o_y0 = s_y0; o_y1 = s_y1;
        end
    end

    task automatic check(input string tag, input int unsigned got, input int unsigned exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pick(input int s);
        sel = s;
        if (s == 0) begin cur_w = 32; cur_h = 32; cur_lat = 1; end
        else        begin cur_w = 16; cur_h = 8;  cur_lat = 3; end
    endtask

    task automatic clear_canvas();
        for (int i = 0; i < 1024; i++) canvas[i] = 1'b0;
    endtask

    task automatic set_px(input int x, input int y);
        canvas[y * cur_w + x] = 1'b1;
    endtask

    task automatic rand_canvas();
        int bx0, bx1, by0, by1, dens;
        clear_canvas();
        bx0  = $urandom_range(cur_w - 1, 0);
        bx1  = $urandom_range(cur_w - 1, bx0);
        by0  = $urandom_range(cur_h - 1, 0);
        by1  = $urandom_range(cur_h - 1, by0);
        dens = $urandom_range(100, 1);
        for (int y = by0; y <= by1; y++)
            for (int x = bx0; x <= bx1; x++)
                if ($urandom_range(99, 0) < dens) set_px(x, y);
    endtask

    // Reference: scan the whole picture, then apply the shape rules.
    task automatic model(output int ink, output int x0, output int x1,
                         output int y0, output int y1, output int ch);
        int wd, ht;
        ink = 0; x0 = 0; x1 = 0; y0 = 0; y1 = 0;
        x0 = cur_w; y0 = cur_h;
        for (int y = 0; y < cur_h; y++)
            for (int x = 0; x < cur_w; x++)
                if (canvas[y * cur_w + x]) begin
                    ink++;
                    if (x < x0) x0 = x;
                    if (x > x1) x1 = x;
                    if (y < y0) y0 = y;
                    if (y > y1) y1 = y;
                end
        if (ink == 0) begin
            x0 = 0; y0 = 0; ch = 'h20;
        end else begin
            wd = x1 - x0 + 1;
            ht = y1 - y0 + 1;
            if (wd >= 2 * ht)      ch = 'h2D;
            else if (ht >= 2 * wd) ch = 'h49;
            else                   ch = 'h41;
        end
    endtask

    // Called at #1 after an edge; end_write is high for exactly the next cycle.
    task automatic pulse_start();
        ew = 1'b1;
        cyc(1);
        ew = 1'b0;
    endtask

    // Current cycle is cycle 1 after the end_write cycle.
    task automatic wait_result(input string tag);
        int cnt;
        cnt = 1;
        while (o_rv == 0 && cnt < 3000) begin
            cyc(1);
            cnt++;
        end
        check({tag, "_latency"}, cnt, cur_w * cur_h + cur_lat + 1);
    endtask

    task automatic check_result(input string tag);
        int ink, x0, x1, y0, y1, ch;
        model(ink, x0, x1, y0, y1, ch);
        check({tag, "_char"}, o_char, ch);
        check({tag, "_ink"},  o_ink,  ink);
        check({tag, "_x0"},   o_x0,   x0);
        check({tag, "_x1"},   o_x1,   x1);
        check({tag, "_y0"},   o_y0,   y0);
        check({tag, "_y1"},   o_y1,   y1);
    endtask

    task automatic hold_and_accept(input string tag);
        int unsigned c0, i0;
        c0 = o_char;
        i0 = o_ink;
        for (int k = 0; k < 20; k++) begin
            cyc(1);
            check({tag, "_hold_valid"}, o_rv, 1);
            check({tag, "_hold_char"},  o_char, c0);
            check({tag, "_hold_ink"},   o_ink, i0);
        end
        rdy = 1'b1;
        cyc(1);
        rdy = 1'b0;
        check({tag, "_accept_valid"}, o_rv, 0);
        check({tag, "_accept_busy"},  o_busy, 0);
    endtask

    task automatic full_scan(input string tag);
        pulse_start();
        wait_result(tag);
        check_result(tag);
        hold_and_accept(tag);
    endtask

    // Restart at a given address with ink that only the first scan can see.
    task automatic abort_scan(input string tag, input int at_addr);
        int guard;
        clear_canvas();
        canvas[0] = 1'b1;
        for (int a = at_addr - 3; a <= at_addr + 3; a++) canvas[a] = 1'b1;
        pulse_start();
        guard = 0;
        while (o_addr != at_addr && guard < 2000) begin
            cyc(1);
            guard++;
        end
        check({tag, "_reach"}, o_addr, at_addr);
        ew = 1'b1;
        cyc(1);
        ew = 1'b0;
        clear_canvas();
        set_px(cur_w - 3, cur_h - 2);
        wait_result(tag);
        check_result(tag);
        hold_and_accept(tag);
    endtask

    initial begin
        rst = 1'b1;
        ew  = 1'b0;
        rdy = 1'b0;
        pick(0);
        clear_canvas();
        cyc(3);
        check("rst_read_enable", o_re, 0);
        check("rst_read_addr",   o_addr, 0);
        check("rst_busy",        o_busy, 0);
        check("rst_valid",       o_rv, 0);
        check("rst_char",        o_char, 'h20);
        check("rst_ink",         o_ink, 0);
        check("rst_bbox",        {o_x0[7:0], o_x1[7:0], o_y0[7:0], o_y1[7:0]}, 0);
        rst = 1'b0;
        cyc(2);

        // Default geometry
        clear_canvas();
        pulse_start();
        check("start_busy", o_busy, 1);
        check("start_re",   o_re, 1);
        check("start_addr", o_addr, 0);
        wait_result("blank");
        check_result("blank");
        hold_and_accept("blank");

        clear_canvas(); set_px(5, 7);
        full_scan("single");

        clear_canvas();
        for (int x = 2; x <= 29; x++) set_px(x, 10);
        full_scan("hline");

        clear_canvas();
        for (int y = 0; y < 32; y++) set_px(3, y);
        full_scan("vline");

        for (int t = 0; t < 3; t++) begin
            rand_canvas();
            full_scan("rand_d");
        end

        abort_scan("abort_d", 500);

        // end_write in DONE with ready high: result dropped, new scan starts
        rand_canvas();
        pulse_start();
        wait_result("done_a");
        check_result("done_a");
        rand_canvas();
        rdy = 1'b1;
        pulse_start();
        rdy = 1'b0;
        check("done_restart_valid", o_rv, 0);
        check("done_restart_busy",  o_busy, 1);
        wait_result("done_b");
        check_result("done_b");
        hold_and_accept("done_b");

        // Reset in the middle of a scan
        clear_canvas(); set_px(1, 1);
        pulse_start();
        cyc(300);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_re",    o_re, 0);
        check("midrst_addr",  o_addr, 0);
        check("midrst_busy",  o_busy, 0);
        check("midrst_valid", o_rv, 0);
        check("midrst_char",  o_char, 'h20);
        check("midrst_ink",   o_ink, 0);
        cyc(1100);
        check("midrst_idle_valid", o_rv, 0);
        check("midrst_idle_busy",  o_busy, 0);

        // Small geometry, RD_LAT=3
        pick(1);
        clear_canvas();
        for (int i = 0; i < 128; i++) canvas[i] = 1'b1;
        full_scan("full_s");
        for (int t = 0; t < 5; t++) begin
            rand_canvas();
            full_scan("rand_s");
        end
        abort_scan("abort_s", 60);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
